s2_window_buffer: RTL and testbench
===================================

S2_WINDOW_BUFFER -- requirements
Module: s2_window_buffer

Interface
REQ-001 Parameter CH, default 6: number of parallel S2 feature maps.
REQ-002 Parameter IMG_W, default 14: input map width in pixels.
REQ-003 Parameter IMG_H, default 14: input map height in pixels.
REQ-004 Parameter K, default 5: square window size for C2.
REQ-005 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_feature_valid  input  1  one pooled pixel per map present this cycle.
REQ-008 i_features  input  signed 8 x CH  pooled pixels, one per map, same (row,col) for all maps.
REQ-009 o_window_valid  output  1  o_window holds a complete KxK window this cycle.
REQ-010 o_window  output  signed 8 x CH x K x K  window per map, indexed [map][row][col], [0][0] = top-left (oldest).
REQ-011 o_frame_done  output  1  single-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 Input arrives raster order, left to right, top to bottom, maps in parallel; i_feature_valid may deassert for any number of cycles between pixels; there is no backpressure.
REQ-013 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance only on accepted pixels; column wraps to 0 and row increments at IMG_W-1; both wrap to 0 after pixel (IMG_H-1, IMG_W-1).
REQ-014 Per map, K-1 line buffers of depth IMG_W store prior rows; on each accepted pixel the K-row column {line buffers, new pixel} shifts into the window register from the right.
REQ-015 o_window_valid is registered: asserted exactly one cycle after an accepted pixel whose row >= K-1 and col >= K-1; deasserted in every other cycle.
REQ-016 Valid windows per frame = (IMG_H-K+1)*(IMG_W-K+1) = 100 at defaults; no window ever spans a row wrap or a frame wrap.
REQ-017 o_window holds its last value while no pixel is accepted; it is meaningful only when o_window_valid = 1.
REQ-018 o_frame_done is asserted one cycle after the pixel (IMG_H-1, IMG_W-1) is accepted, coincident with the final o_window_valid.
REQ-019 Back-to-back frames need no idle cycle; row 0 of the next frame directly follows the last pixel of the previous frame.
REQ-020 Pixel values pass through unmodified; no arithmetic is performed.

Reset
REQ-021 Reset clears the counters, o_window_valid, o_frame_done and every o_window element to 0.
REQ-022 Line buffer contents are not reset; they are don't-care until refilled.
REQ-023 Reset asserted mid-frame abandons the frame; the first pixel after release is (0,0); no window is produced until K-1 new rows have been received.

Configuration
REQ-024 Macro S2_WIN_POS_OUT_EN: when defined, adds outputs o_win_row and o_win_col (each $clog2(IMG_W) bits, reset 0). They give the top-left coordinate (row-K+1, col-K+1) of the current window and are valid with o_window_valid. When undefined, these ports do not exist and the logic is removed.

Structure
REQ-025 The shared CNN package holds CH, IMG_W, IMG_H and K defaults for the S2 stage, plus the feature pixel typedef (signed 8-bit).
REQ-026 One sub-module, s2_line_buffer (one map, K-1 rows x IMG_W, shift on enable), is instantiated CH times.

Verification
REQ-027 Map m carries pixel ((r*14+c)+m) mod 128, continuous valid -> first o_window_valid occurs 1 cycle after input 61; map 0 window [0][0]=0, [4][4]=60; 100 valid windows; o_frame_done on the last of them.
REQ-028 Same frame with i_feature_valid toggled 1,0,0,1,... -> identical window sequence and count; o_window stable during gaps.
REQ-029 Two frames back-to-back, second offset +64 -> 200 windows; the first window of frame 2 has map 0 [0][0]=64 and contains no frame-1 data.
REQ-030 Reset asserted after 30 pixels, then a full frame -> no window before 61 new pixels; 100 windows total.
REQ-031 Pixel (0,13)=-128 and pixel (4,0)=127 -> these values never appear in the same window.
REQ-032 S2_WIN_POS_OUT_EN defined, frame of REQ-027 -> window 1 (o_win_row,o_win_col)=(0,0), window 11=(1,0), window 100=(9,9).

Source files
------------

// File: rtl/s2_window_buffer_pkg.sv
// Shared CNN package: S2-stage geometry defaults and the feature pixel type.
package s2_window_buffer_pkg;

  localparam int S2_CH    = 6;
  localparam int S2_IMG_W = 14;
  localparam int S2_IMG_H = 14;
  localparam int S2_K     = 5;

  typedef logic signed [7:0] pix_t;

endpackage

// File: rtl/s2_window_buffer_if.sv
// Pixel-in / window-out bundle for s2_window_buffer.
// Position outputs exist only when S2_WIN_POS_OUT_EN is defined.
interface s2_window_buffer_if
  import s2_window_buffer_pkg::*;
#(
  parameter int CH    = S2_CH,
  parameter int K     = S2_K,
  parameter int IMG_W = S2_IMG_W
);
  logic                        i_feature_valid;
  pix_t [CH-1:0]               i_features;
  logic                        o_window_valid;
  pix_t [CH-1:0][K-1:0][K-1:0] o_window;
  logic                        o_frame_done;
`ifdef S2_WIN_POS_OUT_EN
  logic [$clog2(IMG_W)-1:0]    o_win_row;
  logic [$clog2(IMG_W)-1:0]    o_win_col;

  modport master (output i_feature_valid, i_features,
                  input  o_window_valid, o_window, o_frame_done, o_win_row, o_win_col);
  modport slave  (input  i_feature_valid, i_features,
                  output o_window_valid, o_window, o_frame_done, o_win_row, o_win_col);
`else
  modport master (output i_feature_valid, i_features,
                  input  o_window_valid, o_window, o_frame_done);
  modport slave  (input  i_feature_valid, i_features,
                  output o_window_valid, o_window, o_frame_done);
`endif
endinterface

// File: rtl/s2_line_buffer.sv
// One map's K-1 prior rows held as a single shift chain; tap j is the pixel
// from j+1 rows before the incoming one.
module s2_line_buffer
  import s2_window_buffer_pkg::*;
#(
  parameter int DEPTH = S2_IMG_W,
  parameter int ROWS  = S2_K - 1
) (
  input  logic            clk,
  input  logic            en,
  input  pix_t            din,
  output pix_t [ROWS-1:0] taps
);

  pix_t [ROWS*DEPTH-1:0] sr;

  // Storage is deliberately unreset; contents are refilled before any window uses them.
  always_ff @(posedge clk) begin
    if (en) sr <= {sr[ROWS*DEPTH-2:0], din};
  end

  for (genvar j = 0; j < ROWS; j++) begin : g_tap
    assign taps[j] = sr[(j+1)*DEPTH-1];
  end

endmodule

// File: rtl/s2_window_buffer.sv
// KxK sliding-window generator over CH parallel raster-order pooled maps.
// Optional S2_WIN_POS_OUT_EN adds the window top-left coordinate outputs.
module s2_window_buffer
  import s2_window_buffer_pkg::*;
#(
  parameter int CH    = S2_CH,
  parameter int IMG_W = S2_IMG_W,
  parameter int IMG_H = S2_IMG_H,
  parameter int K     = S2_K
) (
  input logic                i_clk,
  input logic                i_rst,
  s2_window_buffer_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef logic [CW-1:0] col_t;
  typedef logic [RW-1:0] row_t;

  localparam col_t COL_LAST = col_t'(IMG_W - 1);
  localparam row_t ROW_LAST = row_t'(IMG_H - 1);
  localparam col_t COL_WIN  = col_t'(K - 1);
  localparam row_t ROW_WIN  = row_t'(K - 1);

  col_t col_q;
  row_t row_q;
  logic accept;
  logic win_hit;
  logic last_pix;
  logic valid_q;
  logic done_q;

  pix_t [CH-1:0][K-2:0]          taps;
  pix_t [CH-1:0][K-1:0]          column;
  pix_t [CH-1:0][K-1:0][K-1:0]   win_q;

  assign accept   = bus.i_feature_valid;
  assign win_hit  = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  for (genvar m = 0; m < CH; m++) begin : g_map
    s2_line_buffer #(.DEPTH(IMG_W), .ROWS(K - 1)) u_line_buffer (
      .clk  (i_clk),
      .en   (accept),
      .din  (bus.i_features[m]),
      .taps (taps[m])
    );
  end

  // Row K-1 is the live pixel; higher rows come from progressively older taps.
  always_comb begin
    column = '0;
    for (int unsigned m = 0; m < CH; m++) begin
      for (int unsigned r = 0; r < K - 1; r++) begin
        column[m][r] = taps[m][K-2-r];
      end
      column[m][K-1] = bus.i_features[m];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      valid_q <= accept && win_hit;
      done_q  <= accept && last_pix;
      if (accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        for (int unsigned m = 0; m < CH; m++) begin
          for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
              win_q[m][r][c] <= win_q[m][r][c+1];
            end
            win_q[m][r][K-1] <= column[m][r];
          end
        end
      end
    end
  end

  assign bus.o_window_valid = valid_q;
  assign bus.o_frame_done   = done_q;
  assign bus.o_window       = win_q;

`ifdef S2_WIN_POS_OUT_EN
  col_t win_row_q;
  col_t win_col_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (accept && win_hit) begin
      win_row_q <= col_t'(row_q - ROW_WIN);
      win_col_q <= col_q - COL_WIN;
    end
  end

  assign bus.o_win_row = win_row_q;
  assign bus.o_win_col = win_col_q;
`endif

endmodule

// File: tb/tb_s2_window_buffer.sv
// Self-checking bench for s2_window_buffer: scenario table of frames plus
// spot-value table and a hand-written mid-frame reset sequence.
module tb_s2_window_buffer;
  import s2_window_buffer_pkg::*;

  localparam int CH = S2_CH;
  localparam int W  = S2_IMG_W;
  localparam int H  = S2_IMG_H;
  localparam int K  = S2_K;

  typedef pix_t [CH-1:0][K-1:0][K-1:0] win_t;

  typedef struct {
    int off;       // value offset of first frame
    bit gap;       // valid pattern 1,0,0 when set
    bit special;   // inject -128 at (0,13) and 127 at (4,0)
    int frames;    // frames sent back to back, each +64 on the previous
    int exp_wins;
    int exp_first; // 1-based input index whose acceptance yields window 1
    bit spot;      // run spot table afterwards
  } scen_t;

  typedef struct {
    int win;
    int map;
    int row;
    int col;
    int exp;
  } spot_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  s2_window_buffer_if #(.CH(CH), .K(K), .IMG_W(W)) bus ();

  s2_window_buffer #(.CH(CH), .IMG_W(W), .IMG_H(H), .K(K)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int win_cnt, first_idx, pix_idx, done_cnt, both_cnt;
  win_t prev_win;
  win_t cap [1:256];
`ifdef S2_WIN_POS_OUT_EN
  int cap_row [1:256];
  int cap_col [1:256];
`endif

  scen_t sc [4];
  spot_t sp [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pix_t pix(input int off, input int r, input int c, input int m, input bit special);
    if (special && r == 0 && c == 13) return pix_t'(-128);
    if (special && r == 4 && c == 0) return pix_t'(127);
    return pix_t'(((r * W + c) + m + off) % 128);
  endfunction

  task automatic clear_stats();
    win_cnt   = 0;
    first_idx = -1;
    pix_idx   = 0;
    done_cnt  = 0;
    both_cnt  = 0;
  endtask

  task automatic do_reset();
    bus.i_feature_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    check("reset_valid", int'(bus.o_window_valid), 0);
    check("reset_done", int'(bus.o_frame_done), 0);
    check("reset_window_zero", int'(bus.o_window == '0), 1);
`ifdef S2_WIN_POS_OUT_EN
    check("reset_pos", int'(bus.o_win_row) + int'(bus.o_win_col), 0);
`endif
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    prev_win = bus.o_window;
  endtask

  task automatic step(input int off, input int r, input int c, input bit v, input bit special);
    bit   exp_valid;
    bit   exp_done;
    int   bad;
    bit   has_lo;
    bit   has_hi;
    bus.i_feature_valid = v;
    for (int m = 0; m < CH; m++)
      bus.i_features[m] = v ? pix(off, r, c, m, special) : pix_t'($urandom_range(0, 255));
    @(posedge i_clk);
    #1;
    if (v) pix_idx++;
    exp_valid = v && r >= K - 1 && c >= K - 1;
    exp_done  = v && r == H - 1 && c == W - 1;
    check("window_valid", int'(bus.o_window_valid), int'(exp_valid));
    check("frame_done", int'(bus.o_frame_done), int'(exp_done));
    if (bus.o_frame_done) done_cnt++;
    if (!v) check("window_hold", int'(bus.o_window == prev_win), 1);
    if (bus.o_window_valid && exp_valid) begin
      win_cnt++;
      if (first_idx < 0) first_idx = pix_idx;
      bad    = 0;
      has_lo = 1'b0;
      has_hi = 1'b0;
      for (int m = 0; m < CH; m++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) begin
            if (bus.o_window[m][i][j] != pix(off, r - K + 1 + i, c - K + 1 + j, m, special)) bad++;
            if (m == 0 && bus.o_window[m][i][j] == pix_t'(-128)) has_lo = 1'b1;
            if (m == 0 && bus.o_window[m][i][j] == pix_t'(127)) has_hi = 1'b1;
          end
      check("window_data_mismatches", bad, 0);
      if (has_lo && has_hi) both_cnt++;
      if (win_cnt <= 256) cap[win_cnt] = bus.o_window;
`ifdef S2_WIN_POS_OUT_EN
      check("win_row", int'(bus.o_win_row), r - K + 1);
      check("win_col", int'(bus.o_win_col), c - K + 1);
      if (win_cnt <= 256) begin
        cap_row[win_cnt] = int'(bus.o_win_row);
        cap_col[win_cnt] = int'(bus.o_win_col);
      end
`endif
    end
    prev_win = bus.o_window;
  endtask

  task automatic run_frame(input int off, input bit gap, input bit special, input int npix);
    int n;
    n = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          step(off, r, c, 1'b1, special);
          if (gap) begin
            step(off, r, c, 1'b0, special);
            step(off, r, c, 1'b0, special);
          end
        end
        n++;
      end
  endtask

  initial begin
    sc[0] = '{off: 0, gap: 1'b0, special: 1'b0, frames: 1, exp_wins: 100, exp_first: 61, spot: 1'b1};
    sc[1] = '{off: 0, gap: 1'b1, special: 1'b0, frames: 1, exp_wins: 100, exp_first: 61, spot: 1'b0};
    sc[2] = '{off: 0, gap: 1'b0, special: 1'b0, frames: 2, exp_wins: 200, exp_first: 61, spot: 1'b0};
    sc[3] = '{off: 0, gap: 1'b0, special: 1'b1, frames: 1, exp_wins: 100, exp_first: 61, spot: 1'b0};

    sp[0] = '{win: 1,   map: 0, row: 0, col: 0, exp: 0};
    sp[1] = '{win: 1,   map: 0, row: 4, col: 4, exp: 60};
    sp[2] = '{win: 1,   map: 5, row: 4, col: 4, exp: 65};
    sp[3] = '{win: 11,  map: 0, row: 0, col: 0, exp: 14};
    sp[4] = '{win: 100, map: 0, row: 0, col: 0, exp: 7};
    sp[5] = '{win: 100, map: 0, row: 4, col: 4, exp: 67};
    sp[6] = '{win: 100, map: 5, row: 4, col: 4, exp: 72};

    bus.i_feature_valid = 1'b0;
    bus.i_features      = '0;
    prev_win            = '0;

    for (int s = 0; s < 4; s++) begin
      do_reset();
      clear_stats();
      for (int f = 0; f < sc[s].frames; f++)
        run_frame(sc[s].off + 64 * f, sc[s].gap, sc[s].special, W * H);
      step(0, 0, 0, 1'b0, 1'b0);
      check("window_count", win_cnt, sc[s].exp_wins);
      check("first_window_input", first_idx, sc[s].exp_first);
      check("frame_done_count", done_cnt, sc[s].frames);
      if (sc[s].special) check("special_pair_together", both_cnt, 0);
      if (sc[s].frames == 2) check("frame2_first_map0_00", int'(cap[101][0][0][0]), 64);
      if (sc[s].spot) begin
        for (int t = 0; t < 7; t++)
          check($sformatf("spot_w%0d_m%0d_%0d_%0d", sp[t].win, sp[t].map, sp[t].row, sp[t].col),
                int'(cap[sp[t].win][sp[t].map][sp[t].row][sp[t].col]), sp[t].exp);
`ifdef S2_WIN_POS_OUT_EN
        check("pos_w1_row", cap_row[1], 0);
        check("pos_w1_col", cap_col[1], 0);
        check("pos_w11_row", cap_row[11], 1);
        check("pos_w11_col", cap_col[11], 0);
        check("pos_w100_row", cap_row[100], 9);
        check("pos_w100_col", cap_col[100], 9);
`endif
      end
    end

    // Abandon a frame after 30 pixels; the next frame must restart at (0,0).
    do_reset();
    clear_stats();
    run_frame(0, 1'b0, 1'b0, 30);
    check("partial_no_window", win_cnt, 0);
    check("partial_window_nonzero", int'(bus.o_window != '0), 1);
    do_reset();
    clear_stats();
    run_frame(0, 1'b0, 1'b0, W * H);
    step(0, 0, 0, 1'b0, 1'b0);
    check("after_reset_first_window_input", first_idx, 61);
    check("after_reset_window_count", win_cnt, 100);
    check("after_reset_done_count", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
